// File: rtl/tilemap_pkg.sv
// tilemap_pkg: register offsets and field-width helpers shared by the tilemap fetch generator
package tilemap_pkg;
  localparam logic [1:0] REG_HSCR_LO = 2'd0;
  localparam logic [1:0] REG_HSCR_HI = 2'd1;
  localparam logic [1:0] REG_VSCR = 2'd2;
  function automatic int layer_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic int ra_w(input int lw, input int vbits, input int hbits);
    return lw + vbits + hbits - 5;
  endfunction
  function automatic int ga_w(input int code_w);
    return code_w + 4;
  endfunction
endpackage

// File: rtl/tilemap_layer_regs.sv
// tilemap_layer_regs: per-layer scroll and priority registers with CPU write decode
module tilemap_layer_regs
  import tilemap_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int HBITS = 9,
  parameter int VBITS = 8,
  parameter int LW = layer_w(NUM_LAYERS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  logic [LW+1:0] sel,
  input  logic [7:0] data,
  output logic [NUM_LAYERS*HBITS-1:0] hscroll,
  output logic [NUM_LAYERS*VBITS-1:0] vscroll,
  output logic [NUM_LAYERS*3-1:0] pri
);
  // write the addressed layer's register; reg 3 and layers beyond the count are dropped
  always_ff @(posedge clk)
    if (!rst_n) begin
      hscroll <= '0;
      vscroll <= '0;
      pri <= '0;
    end else if (we)
      for (int i = 0; i < NUM_LAYERS; i++)
        if (sel[LW+1:2] == LW'(i)) begin
          if (sel[1:0] == REG_HSCR_LO) hscroll[i*HBITS +: 8] <= data;
          if (sel[1:0] == REG_HSCR_HI) begin
            hscroll[i*HBITS+8 +: HBITS-8] <= data[HBITS-9:0];
            pri[i*3 +: 3] <= data[3:1];
          end
          if (sel[1:0] == REG_VSCR) vscroll[i*VBITS +: VBITS] <= data[VBITS-1:0];
        end
endmodule

// File: rtl/tilemap_fetch_gen.sv
// tilemap_fetch_gen: N-layer tile RAM fetch scheduler with double-buffered tile codes
module tilemap_fetch_gen
  import tilemap_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int HBITS = 9,
  parameter int VBITS = 8,
  parameter int CODE_W = 10,
  parameter int LW = layer_w(NUM_LAYERS)
) (
  input  logic CLK_6M,
  input  logic nRESET,
  input  logic nHSYNC,
  input  logic nVSYNC,
  input  logic FLIP,
  input  logic nLATCH,
  input  logic [LW+1:0] CA,
  input  logic [7:0] CD,
  input  logic [7:0] RD,
  output logic [ra_w(LW, VBITS, HBITS)-1:0] RA,
  output logic nROE,
  output logic [NUM_LAYERS*ga_w(CODE_W)-1:0] GA,
  output logic [NUM_LAYERS*3-1:0] FINE_X,
  output logic [NUM_LAYERS*3-1:0] PRI,
  output logic [NUM_LAYERS-1:0] TILE_STB
);
  localparam int RAW = ra_w(LW, VBITS, HBITS);
  localparam int GAW = ga_w(CODE_W);
  localparam logic [3:0] SLOTS = 4'(2 * NUM_LAYERS);
  logic [HBITS-1:0] hcnt, sx;
  logic [VBITS-1:0] vcnt, sy;
  logic hs_q, vs_q, nl_q, hs_fall, vs_fall, slot;
  logic [2:0] phase;
  logic [LW-1:0] lay, cap_lay;
  logic [NUM_LAYERS*HBITS-1:0] hscroll;
  logic [NUM_LAYERS*VBITS-1:0] vscroll;
  logic [NUM_LAYERS*3-1:0] pri;
  logic [HBITS-4:0] col [NUM_LAYERS];
  logic [VBITS-1:0] ycoord [NUM_LAYERS];
  logic [CODE_W-1:0] shadow [NUM_LAYERS];
  logic [CODE_W-1:0] active [NUM_LAYERS];
  logic [2:0] trow [NUM_LAYERS];

  assign hs_fall = hs_q & ~nHSYNC;
  assign vs_fall = vs_q & ~nVSYNC;
  assign phase = hcnt[2:0];
  assign slot = {1'b0, phase} < SLOTS;
  assign lay = LW'(phase >> 1);
  assign cap_lay = RA[RAW-1 -: LW];

  tilemap_layer_regs #(
    .NUM_LAYERS(NUM_LAYERS),
    .HBITS(HBITS),
    .VBITS(VBITS),
    .LW(LW)
  ) u_regs (
    .clk(CLK_6M),
    .rst_n(nRESET),
    .we(nl_q & ~nLATCH),
    .sel(CA),
    .data(CD),
    .hscroll(hscroll),
    .vscroll(vscroll),
    .pri(pri)
  );

  // flipped screen position and per-layer scrolled coordinates; the column looks one tile ahead
  always_comb begin
    sx = FLIP ? ~hcnt : hcnt;
    sy = FLIP ? ~vcnt : vcnt;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      col[i] = sx[HBITS-1:3] + (HBITS-3)'(1) + hscroll[i*HBITS+3 +: HBITS-3];
      ycoord[i] = sy + vscroll[i*VBITS +: VBITS];
    end
  end

  // committed code and line per layer, with phase bit 2 picking the tile half
  always_comb
    for (int i = 0; i < NUM_LAYERS; i++) GA[i*GAW +: GAW] = {active[i], trow[i], phase[2]};

  // sync and latch edge detectors plus screen counters; vsync beats the hsync line step
  always_ff @(posedge CLK_6M)
    if (!nRESET) begin
      hcnt <= '0;
      vcnt <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      nl_q <= 1'b1;
    end else begin
      hs_q <= nHSYNC;
      vs_q <= nVSYNC;
      nl_q <= nLATCH;
      hcnt <= hs_fall ? '0 : hcnt + HBITS'(1);
      vcnt <= vs_fall ? '0 : hs_fall ? vcnt + VBITS'(1) : vcnt;
    end

  // issue fetch slots, capture returned bytes into the shadow codes, commit all layers at phase 7
  always_ff @(posedge CLK_6M)
    if (!nRESET) begin
      RA <= '0;
      nROE <= 1'b1;
      TILE_STB <= '0;
      FINE_X <= '0;
      PRI <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
        trow[i] <= '0;
      end
    end else begin
      nROE <= ~slot;
      if (slot) RA <= {lay, ycoord[lay][VBITS-1:3], col[lay], phase[0]};
      if (!nROE) begin
        if (RA[0]) shadow[cap_lay][CODE_W-1:8] <= RD[CODE_W-9:0];
        else shadow[cap_lay][7:0] <= RD;
      end
      TILE_STB <= {NUM_LAYERS{phase == 3'd7}};
      if (phase == 3'd7)
        for (int i = 0; i < NUM_LAYERS; i++) begin
          active[i] <= shadow[i];
          trow[i] <= ycoord[i][2:0];
          FINE_X[i*3 +: 3] <= hscroll[i*HBITS +: 3];
          PRI[i*3 +: 3] <= pri[i*3 +: 3];
        end
    end
endmodule

// File: tb/tb_tilemap_fetch_gen.sv
// tb_tilemap_fetch_gen: directed checks of reset, fetch slots, commit, scroll writes, wrap and sync collision
module tb_tilemap_fetch_gen;
  logic CLK_6M = 1'b0;
  logic nRESET, nHSYNC, nVSYNC, FLIP, nLATCH;
  logic [2:0] CA;
  logic [7:0] CD, RD;
  logic [12:0] RA;
  logic nROE;
  logic [27:0] GA;
  logic [5:0] FINE_X, PRI;
  logic [1:0] TILE_STB;
  int checks = 0;
  int errors = 0;
  int lows = 0;
  logic [12:0] fetch_ra [4] = '{13'h0082, 13'h0083, 13'h1082, 13'h1083};
  logic [7:0] fetch_rd [4] = '{8'h34, 8'h03, 8'h56, 8'h01};
  logic [12:0] wrap_ra [4] = '{13'h0080, 13'h0081, 13'h10C6, 13'h10C7};

  always #5 CLK_6M = ~CLK_6M;

  tilemap_fetch_gen dut (
    .CLK_6M(CLK_6M),
    .nRESET(nRESET),
    .nHSYNC(nHSYNC),
    .nVSYNC(nVSYNC),
    .FLIP(FLIP),
    .nLATCH(nLATCH),
    .CA(CA),
    .CD(CD),
    .RD(RD),
    .RA(RA),
    .nROE(nROE),
    .GA(GA),
    .FINE_X(FINE_X),
    .PRI(PRI),
    .TILE_STB(TILE_STB)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK_6M);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    CA = a;
    CD = d;
    nLATCH = 1'b0;
    tick();
    nLATCH = 1'b1;
    tick();
  endtask

  initial begin
    nRESET = 1'b0;
    nHSYNC = 1'b1;
    nVSYNC = 1'b1;
    FLIP = 1'b0;
    nLATCH = 1'b1;
    CA = '0;
    CD = '0;
    RD = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_nroe", nROE, 1);
      check("rst_ra", RA, 0);
      check("rst_ga", GA, 0);
      check("rst_stb", TILE_STB, 0);
    end
    nRESET = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nHSYNC = 1'b0;
      tick();
      nHSYNC = 1'b1;
      if (i < 7) tick();
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      check("fetch_ra", RA, fetch_ra[(k < 4) ? k : 3]);
      check("fetch_nroe", nROE, (k < 4) ? 0 : 1);
      lows += (nROE == 1'b0) ? 1 : 0;
      if (k < 4) RD = fetch_rd[k];
      if (k == 3) check("half_hi", GA[13:0], 14'h0001);
      if (k == 6) check("stb_pre", TILE_STB, 0);
    end
    check("nroe_lows", lows, 4);
    check("commit_stb", TILE_STB, 2'b11);
    check("commit_ga0", GA[13:0], 14'h3340);
    check("commit_ga1", GA[27:14], 14'h1560);
    tick();
    check("stb_post", TILE_STB, 0);
    check("next_col_ra", RA, 13'h0084);
    check("next_col_nroe", nROE, 0);
    wr(3'b100, 8'h12);
    wr(3'b101, 8'h0B);
    wr(3'b000, 8'hF8);
    wr(3'b001, 8'h01);
    nHSYNC = 1'b0;
    tick();
    nHSYNC = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k < 4) check("wrap_ra", RA, wrap_ra[k]);
    end
    check("wrap_stb", TILE_STB, 2'b11);
    check("wrap_fine_x", FINE_X, 6'h10);
    check("wrap_pri", PRI, 6'h28);
    check("wrap_trow", GA[3:1], 3'd1);
    nHSYNC = 1'b0;
    nVSYNC = 1'b0;
    tick();
    nHSYNC = 1'b1;
    nVSYNC = 1'b1;
    FLIP = 1'b1;
    tick();
    check("flip_ra", RA, 13'h0FFE);
    check("flip_nroe", nROE, 0);
    for (int k = 1; k < 8; k++) tick();
    check("flip_stb", TILE_STB, 2'b11);
    check("flip_trow", GA[3:1], 3'd7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
